// File: rtl/glb_load_sequencer.sv
// glb_load_sequencer
// Sits between the host 32-bit word stream and the accelerator's global
// buffers. One host stream is split into the ifmap, weight and bias buffers,
// each filled from address 0 upwards. After loading, the sequencer kicks the
// PE array, counts the drained ofmap words, and repeats for the second step
// of the layer. In mode 1 the second step skips the bias load because the
// step-0 accumulators are kept as bias (psum_keep).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mode, start              layer mode (latched on start from IDLE/DONE), step kick
//   in_valid/in_data/in_ready host word handshake
//   ifmap_we/ifmap_addr      ifmap buffer write
//   weight_we/weight_addr    weight buffer write
//   bias_we/bias_addr        bias buffer write
//   glb_wdata                write data shared by all three buffers
//   compute_start, psum_keep PE array control
//   compute_done, ofmap_valid PE array / PPU status
//   step, busy, done, err    status
module glb_load_sequencer #(
    parameter int IFMAP_WORDS  = 16,
    parameter int WEIGHT_WORDS = 1024,
    parameter int BIAS_WORDS   = 64,
    parameter int OFMAP_WORDS  = 64,
    localparam int IW = $clog2(IFMAP_WORDS),
    localparam int WW = $clog2(WEIGHT_WORDS),
    localparam int BW = $clog2(BIAS_WORDS),
    localparam int OW = $clog2(OFMAP_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          start,
    input  logic          in_valid,
    input  logic [31:0]   in_data,
    output logic          in_ready,
    output logic          ifmap_we,
    output logic [IW-1:0] ifmap_addr,
    output logic          weight_we,
    output logic [WW-1:0] weight_addr,
    output logic          bias_we,
    output logic [BW-1:0] bias_addr,
    output logic [31:0]   glb_wdata,
    output logic          compute_start,
    output logic          psum_keep,
    input  logic          compute_done,
    input  logic          ofmap_valid,
    output logic          step,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LD_IFMAP, S_LD_WEIGHT, S_LD_BIAS,
        S_COMPUTE, S_DRAIN, S_WAIT_NEXT, S_DONE
    } state_t;

    localparam logic [IW-1:0] IFMAP_LAST  = IW'(IFMAP_WORDS - 1);
    localparam logic [WW-1:0] WEIGHT_LAST = WW'(WEIGHT_WORDS - 1);
    localparam logic [BW-1:0] BIAS_LAST   = BW'(BIAS_WORDS - 1);
    localparam logic [OW-1:0] OFMAP_LAST  = OW'(OFMAP_WORDS - 1);

    state_t          state_reg, state_next;
    logic            step_reg, step_next;
    logic            mode_reg, mode_next;
    logic            first_reg, first_next;   // high on the first COMPUTE cycle only
    logic            err_reg, err_next;
    logic [IW-1:0]   ifmap_cnt_reg, ifmap_cnt_next;
    logic [WW-1:0]   weight_cnt_reg, weight_cnt_next;
    logic [BW-1:0]   bias_cnt_reg, bias_cnt_next;
    logic [OW-1:0]   ofmap_cnt_reg, ofmap_cnt_next;
    logic            ifmap_we_reg, ifmap_we_next;
    logic            weight_we_reg, weight_we_next;
    logic            bias_we_reg, bias_we_next;
    logic [IW-1:0]   ifmap_addr_reg, ifmap_addr_next;
    logic [WW-1:0]   weight_addr_reg, weight_addr_next;
    logic [BW-1:0]   bias_addr_reg, bias_addr_next;
    logic [31:0]     wdata_reg, wdata_next;
    logic            accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            step_reg        <= 1'b0;
            mode_reg        <= 1'b0;
            first_reg       <= 1'b0;
            err_reg         <= 1'b0;
            ifmap_cnt_reg   <= '0;
            weight_cnt_reg  <= '0;
            bias_cnt_reg    <= '0;
            ofmap_cnt_reg   <= '0;
            ifmap_we_reg    <= 1'b0;
            weight_we_reg   <= 1'b0;
            bias_we_reg     <= 1'b0;
            ifmap_addr_reg  <= '0;
            weight_addr_reg <= '0;
            bias_addr_reg   <= '0;
            wdata_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            step_reg        <= step_next;
            mode_reg        <= mode_next;
            first_reg       <= first_next;
            err_reg         <= err_next;
            ifmap_cnt_reg   <= ifmap_cnt_next;
            weight_cnt_reg  <= weight_cnt_next;
            bias_cnt_reg    <= bias_cnt_next;
            ofmap_cnt_reg   <= ofmap_cnt_next;
            ifmap_we_reg    <= ifmap_we_next;
            weight_we_reg   <= weight_we_next;
            bias_we_reg     <= bias_we_next;
            ifmap_addr_reg  <= ifmap_addr_next;
            weight_addr_reg <= weight_addr_next;
            bias_addr_reg   <= bias_addr_next;
            wdata_reg       <= wdata_next;
        end
    end

    // Moore handshake: ready purely from the registered state, so it drops
    // the cycle after the last word of the final load state is accepted.
    assign in_ready = (state_reg == S_LD_IFMAP) || (state_reg == S_LD_WEIGHT) ||
                      (state_reg == S_LD_BIAS);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next       = state_reg;
        step_next        = step_reg;
        mode_next        = mode_reg;
        first_next       = 1'b0;
        ifmap_cnt_next   = ifmap_cnt_reg;
        weight_cnt_next  = weight_cnt_reg;
        bias_cnt_next    = bias_cnt_reg;
        ofmap_cnt_next   = ofmap_cnt_reg;
        ifmap_we_next    = 1'b0;
        weight_we_next   = 1'b0;
        bias_we_next     = 1'b0;
        ifmap_addr_next  = ifmap_addr_reg;
        weight_addr_next = weight_addr_reg;
        bias_addr_next   = bias_addr_reg;
        wdata_next       = wdata_reg;

        // Protocol violations are sticky until reset.
        err_next = err_reg
                 | (ofmap_valid && (state_reg != S_DRAIN))
                 | (compute_done && ((state_reg != S_COMPUTE) || first_reg));

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_next       = mode;
                    step_next       = 1'b0;
                    ifmap_cnt_next  = '0;
                    weight_cnt_next = '0;
                    bias_cnt_next   = '0;
                    ofmap_cnt_next  = '0;
                    state_next      = S_LD_IFMAP;
                end
            end
            S_WAIT_NEXT: begin
                if (start) begin
                    ifmap_cnt_next  = '0;
                    weight_cnt_next = '0;
                    bias_cnt_next   = '0;
                    ofmap_cnt_next  = '0;
                    state_next      = S_LD_IFMAP;
                end
            end
            S_LD_IFMAP: begin
                if (accept) begin
                    ifmap_we_next   = 1'b1;
                    ifmap_addr_next = ifmap_cnt_reg;
                    wdata_next      = in_data;
                    if (ifmap_cnt_reg == IFMAP_LAST) begin
                        ifmap_cnt_next = '0;
                        state_next     = S_LD_WEIGHT;
                    end else begin
                        ifmap_cnt_next = ifmap_cnt_reg + IW'(1);
                    end
                end
            end
            S_LD_WEIGHT: begin
                if (accept) begin
                    weight_we_next   = 1'b1;
                    weight_addr_next = weight_cnt_reg;
                    wdata_next       = in_data;
                    if (weight_cnt_reg == WEIGHT_LAST) begin
                        weight_cnt_next = '0;
                        // Mode 1, step 1: bias comes from the kept accumulators.
                        if (mode_reg && step_reg) begin
                            state_next = S_COMPUTE;
                            first_next = 1'b1;
                        end else begin
                            state_next = S_LD_BIAS;
                        end
                    end else begin
                        weight_cnt_next = weight_cnt_reg + WW'(1);
                    end
                end
            end
            S_LD_BIAS: begin
                if (accept) begin
                    bias_we_next   = 1'b1;
                    bias_addr_next = bias_cnt_reg;
                    wdata_next     = in_data;
                    if (bias_cnt_reg == BIAS_LAST) begin
                        bias_cnt_next = '0;
                        state_next    = S_COMPUTE;
                        first_next    = 1'b1;
                    end else begin
                        bias_cnt_next = bias_cnt_reg + BW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                // A done on the kick cycle cannot be genuine; it is flagged
                // above and otherwise ignored.
                if (compute_done && !first_reg) begin
                    ofmap_cnt_next = '0;
                    state_next     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ofmap_valid) begin
                    if (ofmap_cnt_reg == OFMAP_LAST) begin
                        ofmap_cnt_next = '0;
                        if (!step_reg) begin
                            step_next  = 1'b1;
                            state_next = S_WAIT_NEXT;
                        end else begin
                            state_next = S_DONE;
                        end
                    end else begin
                        ofmap_cnt_next = ofmap_cnt_reg + OW'(1);
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign ifmap_we      = ifmap_we_reg;
    assign ifmap_addr    = ifmap_addr_reg;
    assign weight_we     = weight_we_reg;
    assign weight_addr   = weight_addr_reg;
    assign bias_we       = bias_we_reg;
    assign bias_addr     = bias_addr_reg;
    assign glb_wdata     = wdata_reg;
    assign compute_start = (state_reg == S_COMPUTE) && first_reg;
    assign psum_keep     = (state_reg == S_COMPUTE) && mode_reg && step_reg;
    assign step          = step_reg;
    assign busy          = !((state_reg == S_IDLE) || (state_reg == S_WAIT_NEXT) ||
                             (state_reg == S_DONE));
    assign done          = (state_reg == S_DONE);
    assign err           = err_reg;

endmodule

// File: tb/tb_glb_load_sequencer.sv
// Directed testbench for glb_load_sequencer. Host words carry a buffer tag in
// the top byte and the word index below it, so every GLB write can be checked
// for address and data by a write monitor.
module tb_glb_load_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        ifmap_we;
    logic [3:0]  ifmap_addr;
    logic        weight_we;
    logic [9:0]  weight_addr;
    logic        bias_we;
    logic [5:0]  bias_addr;
    logic [31:0] glb_wdata;
    logic        compute_start;
    logic        psum_keep;
    logic        compute_done = 1'b0;
    logic        ofmap_valid = 1'b0;
    logic        step;
    logic        busy;
    logic        done;
    logic        err;

    int n_compared = 0;
    int n_mismatched = 0;

    // write monitor state
    int idx_i = 0, idx_w = 0, idx_b = 0;
    int tot_i = 0, tot_w = 0, tot_b = 0;

    glb_load_sequencer dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ifmap_we(ifmap_we), .ifmap_addr(ifmap_addr),
        .weight_we(weight_we), .weight_addr(weight_addr),
        .bias_we(bias_we), .bias_addr(bias_addr),
        .glb_wdata(glb_wdata), .compute_start(compute_start),
        .psum_keep(psum_keep), .compute_done(compute_done),
        .ofmap_valid(ofmap_valid), .step(step), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every write must land on the next consecutive address with the tagged data.
    always @(negedge clk) begin
        if (ifmap_we) begin
            check("ifmap_addr", 32'(ifmap_addr), 32'(idx_i));
            check("ifmap_data", glb_wdata, {8'd1, 24'(idx_i)});
            idx_i = (idx_i + 1) % 16;
            tot_i++;
        end
        if (weight_we) begin
            check("weight_addr", 32'(weight_addr), 32'(idx_w));
            check("weight_data", glb_wdata, {8'd2, 24'(idx_w)});
            idx_w = (idx_w + 1) % 1024;
            tot_w++;
        end
        if (bias_we) begin
            check("bias_addr", 32'(bias_addr), 32'(idx_b));
            check("bias_data", glb_wdata, {8'd3, 24'(idx_b)});
            idx_b = (idx_b + 1) % 64;
            tot_b++;
        end
        if (rst) begin
            idx_i = 0;
            idx_w = 0;
            idx_b = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start(input logic m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    // Send n words tagged b, indices first..first+n-1; optional random idle gaps.
    task automatic send(input int b, input int first, input int n, input bit gaps);
        int i = 0;
        int stall = 0;
        bit acc;
        while (i < n) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = {8'(b), 24'(first + i)};
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                i++;
                stall = 0;
            end else if (in_valid) begin
                stall++;
                if (stall > 8) begin
                    check("ready_stall", 32'(in_ready), 32'd1);
                    i = n;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // Called on the compute_start cycle; leaves the DUT in DRAIN.
    task automatic run_compute();
        tick();
        tick();
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
    endtask

    task automatic run_drain(input bit spur, input logic cur_step);
        for (int i = 0; i < 64; i++) begin
            ofmap_valid = 1'b1;
            start = spur && (i == 10);
            tick();
            start = 1'b0;
            if (i == 62) begin
                check("drain_step_hold", 32'(step), 32'(cur_step));
                check("drain_busy", 32'(busy), 32'd1);
            end
        end
        ofmap_valid = 1'b0;
    endtask

    // One full step, starting just after the start pulse was accepted.
    task automatic do_step(input bit spur, input bit gaps, input bit with_bias, input logic cur_step);
        int si = tot_i, sw = tot_w, sb = tot_b;
        send(1, 0, 16, 1'b0);
        send(2, 0, 1024, gaps);
        if (with_bias) send(3, 0, 64, 1'b0);
        check("kick", 32'(compute_start), 32'd1);
        check("kick_ready_low", 32'(in_ready), 32'd0);
        check("kick_psum_keep", 32'(psum_keep), 32'(!with_bias));
        if (!with_bias) begin
            // extra word offered after the last weight: must not be taken
            in_valid = 1'b1;
            in_data  = {8'd2, 24'd1024};
            tick();
            check("extra_word_we", 32'(weight_we), 32'd0);
            in_valid = 1'b0;
            check("psum_keep_hold", 32'(psum_keep), 32'd1);
            compute_done = 1'b1;
            tick();
            compute_done = 1'b0;
        end else begin
            run_compute();
        end
        check("drain_psum_keep", 32'(psum_keep), 32'd0);
        run_drain(spur, cur_step);
        check("end_step", 32'(step), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_done", 32'(done), 32'(cur_step));
        check("ifmap_writes", 32'(tot_i - si), 32'd16);
        check("weight_writes", 32'(tot_w - sw), 32'd1024);
        check("bias_writes", 32'(tot_b - sb), with_bias ? 32'd64 : 32'd0);
    endtask

    initial begin
        // ---------- reset state ----------
        do_reset();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_ifmap_we", 32'(ifmap_we), 32'd0);
        check("rst_weight_we", 32'(weight_we), 32'd0);
        check("rst_bias_we", 32'(bias_we), 32'd0);
        check("rst_addrs", {ifmap_addr, weight_addr, bias_addr}, 32'd0);
        check("rst_wdata", glb_wdata, 32'd0);
        check("rst_ctl", {compute_start, psum_keep, busy, done, err, step}, 32'd0);

        // ---------- mode 0, two steps, spurious start in the second drain ----------
        pulse_start(1'b0);
        check("ld_ready", 32'(in_ready), 32'd1);
        check("ld_busy", 32'(busy), 32'd1);
        do_step(1'b0, 1'b0, 1'b1, 1'b0);
        pulse_start(1'b0);
        do_step(1'b1, 1'b0, 1'b1, 1'b1);
        check("m0_err", 32'(err), 32'd0);

        // ---------- mode 1 from DONE; step 1 skips bias, weights with gaps ----------
        pulse_start(1'b1);
        check("restart_done_drop", 32'(done), 32'd0);
        check("restart_step", 32'(step), 32'd0);
        do_step(1'b0, 1'b0, 1'b1, 1'b0);
        pulse_start(1'b0);   // mode is not resampled in WAIT_NEXT
        do_step(1'b0, 1'b1, 1'b0, 1'b1);
        check("m1_err", 32'(err), 32'd0);

        // ---------- ofmap_valid during weight load: sticky err ----------
        do_reset();
        check("err_clear", 32'(err), 32'd0);
        pulse_start(1'b0);
        send(1, 0, 16, 1'b0);
        send(2, 0, 100, 1'b0);
        ofmap_valid = 1'b1;
        tick();
        ofmap_valid = 1'b0;
        check("err_ofmap", 32'(err), 32'd1);
        send(2, 100, 924, 1'b0);
        send(3, 0, 64, 1'b0);
        run_compute();
        run_drain(1'b0, 1'b0);
        check("err_sticky_wait", 32'(err), 32'd1);
        pulse_start(1'b0);
        do_step(1'b0, 1'b0, 1'b1, 1'b1);
        check("err_sticky_done", 32'(err), 32'd1);

        // ---------- compute_done on the kick cycle ----------
        do_reset();
        pulse_start(1'b0);
        send(1, 0, 16, 1'b0);
        send(2, 0, 1024, 1'b0);
        send(3, 0, 64, 1'b0);
        check("early_kick", 32'(compute_start), 32'd1);
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        check("err_early_done", 32'(err), 32'd1);
        check("early_kick_once", 32'(compute_start), 32'd0);
        // still in COMPUTE: a full burst of ofmap pulses must not finish a drain
        ofmap_valid = 1'b1;
        repeat (64) tick();
        ofmap_valid = 1'b0;
        check("early_stay_compute", 32'(busy), 32'd1);
        run_compute();
        run_drain(1'b0, 1'b0);
        check("early_then_wait", {30'd0, step, busy}, 32'b10);

        // ---------- reset mid-load ----------
        do_reset();
        pulse_start(1'b0);
        send(1, 0, 16, 1'b0);
        send(2, 0, 500, 1'b0);
        check("pre_rst_we", 32'(weight_we), 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_we", {29'd0, ifmap_we, weight_we, bias_we}, 32'd0);
        check("midrst_ctl", {in_ready, compute_start, psum_keep, busy, done, err, step}, 32'd0);
        check("midrst_wdata", glb_wdata, 32'd0);
        check("midrst_addr", {ifmap_addr, weight_addr, bias_addr}, 32'd0);
        // start coincident with reset is lost
        start = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b0;
        tick();
        check("rst_start_lost", 32'(busy), 32'd0);
        pulse_start(1'b0);
        send(1, 0, 1, 1'b0);
        check("restart_we", 32'(ifmap_we), 32'd1);
        check("restart_addr", 32'(ifmap_addr), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
